traffic_light_ctrl: RTL and testbench

Parametrised N-phase traffic-light controller, the generalised successor to the fixed three-signal-group intersection FSM. Phase 0 is the main road and rests in green. Phases 1..NUM_PHASES-1 are side roads or crossings served on sensor request in round-robin order. Green, yellow and all-red intervals are set per build via parameters, and every output is registered.

---
 rtl/traffic_light_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_traffic_light_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_ctrl.sv
// N-phase traffic-light controller: phase 0 (main road) rests in green, side phases served round-robin on request.
// All outputs registered; optional flash mode is compiled in with `define TL_FLASH_EN.
module traffic_light_ctrl #(
    parameter int NUM_PHASES = 3,
    parameter int CNT_W      = 8,
    parameter int GREEN_MIN  = 4,
    parameter int GREEN_MAX  = 10,
    parameter int YELLOW_T   = 2,
    parameter int ALLRED_T   = 1,
    parameter int FLASH_HALF = 8,
    localparam int PH_W      = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_PHASES-1:0] req,
`ifdef TL_FLASH_EN
    input  logic                  flash,
`endif
    output logic [NUM_PHASES-1:0] green,
    output logic [NUM_PHASES-1:0] yellow,
    output logic [NUM_PHASES-1:0] red,
    output logic [PH_W-1:0]       phase
);

`ifdef TL_FLASH_EN
    typedef enum logic [1:0] {ST_GREEN, ST_YELLOW, ST_ALLRED, ST_FLASH} state_t;
`else
    typedef enum logic [1:0] {ST_GREEN, ST_YELLOW, ST_ALLRED} state_t;
`endif

    localparam logic [NUM_PHASES-1:0] ONE       = {{(NUM_PHASES-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]      GMIN_LAST = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0]      GMAX_LAST = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0]      Y_LAST    = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0]      AR_LAST   = CNT_W'(ALLRED_T - 1);

    state_t                  state_q, state_d;
    logic [PH_W-1:0]         phase_q, phase_d;
    logic [PH_W-1:0]         next_q, next_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_PHASES-1:0]   pending_q, pending_d;
    logic [NUM_PHASES-1:0]   green_q, green_d;
    logic [NUM_PHASES-1:0]   yellow_q, yellow_d;
    logic [NUM_PHASES-1:0]   red_q, red_d;
`ifdef TL_FLASH_EN
    localparam logic [CNT_W-1:0] FH_LAST = CNT_W'(FLASH_HALF - 1);
    logic                    flash_on_q, flash_on_d;
`endif

    logic [PH_W-1:0]         nxt_sel;
    logic [NUM_PHASES-1:0]   cur_mask;
    logic [NUM_PHASES-1:0]   clr_mask;
    logic                    leave_green;
    logic                    enter_green;

    // Round-robin pick: a candidate above the current phase beats any wrap-around candidate.
    always_comb begin
        nxt_sel = '0;
        for (int i = NUM_PHASES - 1; i >= 1; i--) begin
            if (pending_q[i] && (PH_W'(i) < phase_q)) nxt_sel = PH_W'(i);
        end
        for (int i = NUM_PHASES - 1; i >= 1; i--) begin
            if (pending_q[i] && (PH_W'(i) > phase_q)) nxt_sel = PH_W'(i);
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        next_d      = next_q;
        cnt_d       = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        cur_mask    = ONE << phase_q;
        leave_green = 1'b0;
        enter_green = 1'b0;
`ifdef TL_FLASH_EN
        flash_on_d  = flash_on_q;
`endif

        case (state_q)
            ST_GREEN: begin
                if (phase_q == '0) begin
                    leave_green = (cnt_q >= GMIN_LAST) && (|pending_q);
                end else begin
                    leave_green = (cnt_q >= GMIN_LAST) &&
                                  (!req[phase_q] ||
                                   ((cnt_q >= GMAX_LAST) && (|(pending_q & ~cur_mask))));
                end
`ifdef TL_FLASH_EN
                if (flash) leave_green = 1'b1;
`endif
                if (leave_green) begin
                    state_d = ST_YELLOW;
                    next_d  = nxt_sel;
                end
            end
            ST_YELLOW: begin
                if (cnt_q >= Y_LAST) state_d = ST_ALLRED;
            end
            ST_ALLRED: begin
                if (cnt_q >= AR_LAST) begin
`ifdef TL_FLASH_EN
                    if (flash) begin
                        state_d = ST_FLASH;
                    end else begin
                        state_d     = ST_GREEN;
                        phase_d     = next_q;
                        enter_green = 1'b1;
                    end
`else
                    state_d     = ST_GREEN;
                    phase_d     = next_q;
                    enter_green = 1'b1;
`endif
                end
            end
`ifdef TL_FLASH_EN
            ST_FLASH: begin
                if (!flash) begin
                    state_d = ST_ALLRED;
                    next_d  = '0;
                end else if (cnt_q >= FH_LAST) begin
                    cnt_d      = '0;
                    flash_on_d = ~flash_on_q;
                end
            end
`endif
            default: state_d = ST_GREEN;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
`ifdef TL_FLASH_EN
            flash_on_d = 1'b1;
`endif
        end

        // A new request on the same edge as the grant keeps the bit set.
        clr_mask  = enter_green ? (ONE << next_q) : '0;
        pending_d = (pending_q & ~clr_mask) | (req & ~ONE);

        green_d  = '0;
        yellow_d = '0;
        red_d    = '1;
        case (state_d)
            ST_GREEN: begin
                green_d = ONE << phase_d;
                red_d   = ~green_d;
            end
            ST_YELLOW: begin
                yellow_d = ONE << phase_d;
                red_d    = ~yellow_d;
            end
`ifdef TL_FLASH_EN
            ST_FLASH: begin
                red_d    = '0;
                yellow_d = {NUM_PHASES{flash_on_d}};
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_GREEN;
            phase_q    <= '0;
            next_q     <= '0;
            cnt_q      <= '0;
            pending_q  <= '0;
            green_q    <= ONE;
            yellow_q   <= '0;
            red_q      <= ~ONE;
`ifdef TL_FLASH_EN
            flash_on_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            next_q     <= next_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            green_q    <= green_d;
            yellow_q   <= yellow_d;
            red_q      <= red_d;
`ifdef TL_FLASH_EN
            flash_on_q <= flash_on_d;
`endif
        end
    end

    assign green  = green_q;
    assign yellow = yellow_q;
    assign red    = red_q;
    assign phase  = phase_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl (3 phases); flash scenario compiled only with TL_FLASH_EN.
module tb_traffic_light_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] req = 3'b000;
`ifdef TL_FLASH_EN
    logic       flash = 1'b0;
`endif
    logic [2:0] green, yellow, red;
    logic [1:0] phase;

    int checks = 0;
    int errors = 0;

    // Expected per-cycle {green, yellow, red, phase}
    logic [10:0] exp_q[$];

    traffic_light_ctrl #(
        .NUM_PHASES(3), .CNT_W(8), .GREEN_MIN(4), .GREEN_MAX(10),
        .YELLOW_T(2), .ALLRED_T(1), .FLASH_HALF(8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
`ifdef TL_FLASH_EN
        .flash (flash),
`endif
        .green (green),
        .yellow(yellow),
        .red   (red),
        .phase (phase)
    );

    always #5 clk = ~clk;

    task automatic seg(input int n, input logic [2:0] g, input logic [2:0] y,
                       input logic [2:0] r, input logic [1:0] ph);
        for (int i = 0; i < n; i++) exp_q.push_back({g, y, r, ph});
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        req = 3'b000;
`ifdef TL_FLASH_EN
        flash = 1'b0;
`endif
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({green, yellow, red, phase} !== {3'b001, 3'b000, 3'b110, 2'd0}) begin
            errors++;
            $display("FAIL reset_async: got g=%b y=%b r=%b ph=%0d, expected g=001 y=000 r=110 ph=0",
                     green, yellow, red, phase);
        end
        @(posedge clk); #1 rst = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({green, yellow, red, phase} !== {3'b001, 3'b000, 3'b110, 2'd0}) begin
                errors++;
                $display("FAIL reset_idle cyc %0d: got g=%b y=%b r=%b ph=%0d, expected g=001 y=000 r=110 ph=0",
                         c, green, yellow, red, phase);
            end
        end
    endtask

    task automatic test_single_side();
        logic [10:0] e;
        do_reset();
        repeat (20) @(posedge clk);
        exp_q.delete();
        seg(2, 3'b001, 3'b000, 3'b110, 2'd0);
        seg(2, 3'b000, 3'b001, 3'b110, 2'd0);
        seg(1, 3'b000, 3'b000, 3'b111, 2'd0);
        seg(4, 3'b100, 3'b000, 3'b011, 2'd2);
        seg(2, 3'b000, 3'b100, 3'b011, 2'd2);
        seg(1, 3'b000, 3'b000, 3'b111, 2'd2);
        seg(3, 3'b001, 3'b000, 3'b110, 2'd0);
        for (int c = 0; c < exp_q.size(); c++) begin
            @(posedge clk); #1;
            e = exp_q[c];
            checks++;
            if ({green, yellow, red, phase} !== e) begin
                errors++;
                $display("FAIL single_side cyc %0d: got g=%b y=%b r=%b ph=%0d, expected g=%b y=%b r=%b ph=%0d",
                         c, green, yellow, red, phase, e[10:8], e[7:5], e[4:2], e[1:0]);
            end
            req = (c == 0) ? 3'b100 : 3'b000;
        end
    endtask

    task automatic test_round_robin();
        logic [10:0] e;
        do_reset();
        repeat (8) @(posedge clk);
        exp_q.delete();
        seg(2, 3'b001, 3'b000, 3'b110, 2'd0);
        seg(2, 3'b000, 3'b001, 3'b110, 2'd0);
        seg(1, 3'b000, 3'b000, 3'b111, 2'd0);
        seg(4, 3'b010, 3'b000, 3'b101, 2'd1);
        seg(2, 3'b000, 3'b010, 3'b101, 2'd1);
        seg(1, 3'b000, 3'b000, 3'b111, 2'd1);
        seg(4, 3'b100, 3'b000, 3'b011, 2'd2);
        seg(2, 3'b000, 3'b100, 3'b011, 2'd2);
        seg(1, 3'b000, 3'b000, 3'b111, 2'd2);
        seg(3, 3'b001, 3'b000, 3'b110, 2'd0);
        for (int c = 0; c < exp_q.size(); c++) begin
            @(posedge clk); #1;
            e = exp_q[c];
            checks++;
            if ({green, yellow, red, phase} !== e) begin
                errors++;
                $display("FAIL round_robin cyc %0d: got g=%b y=%b r=%b ph=%0d, expected g=%b y=%b r=%b ph=%0d",
                         c, green, yellow, red, phase, e[10:8], e[7:5], e[4:2], e[1:0]);
            end
            req = (c == 0) ? 3'b110 : 3'b000;
        end
    endtask

    task automatic test_green_max();
        logic [10:0] e;
        do_reset();
        repeat (8) @(posedge clk);
        exp_q.delete();
        seg(2,  3'b001, 3'b000, 3'b110, 2'd0);
        seg(2,  3'b000, 3'b001, 3'b110, 2'd0);
        seg(1,  3'b000, 3'b000, 3'b111, 2'd0);
        seg(10, 3'b010, 3'b000, 3'b101, 2'd1);
        seg(2,  3'b000, 3'b010, 3'b101, 2'd1);
        seg(1,  3'b000, 3'b000, 3'b111, 2'd1);
        seg(4,  3'b100, 3'b000, 3'b011, 2'd2);
        seg(2,  3'b000, 3'b100, 3'b011, 2'd2);
        seg(1,  3'b000, 3'b000, 3'b111, 2'd2);
        // phase 1 re-requested itself while it held green
        seg(4,  3'b010, 3'b000, 3'b101, 2'd1);
        seg(2,  3'b000, 3'b010, 3'b101, 2'd1);
        seg(1,  3'b000, 3'b000, 3'b111, 2'd1);
        seg(4,  3'b001, 3'b000, 3'b110, 2'd0);
        for (int c = 0; c < exp_q.size(); c++) begin
            @(posedge clk); #1;
            e = exp_q[c];
            checks++;
            if ({green, yellow, red, phase} !== e) begin
                errors++;
                $display("FAIL green_max cyc %0d: got g=%b y=%b r=%b ph=%0d, expected g=%b y=%b r=%b ph=%0d",
                         c, green, yellow, red, phase, e[10:8], e[7:5], e[4:2], e[1:0]);
            end
            if (c == 6)       req = 3'b110;
            else if (c < 15)  req = 3'b010;
            else              req = 3'b000;
        end
    endtask

    task automatic test_hold();
        logic [10:0] e;
        do_reset();
        repeat (8) @(posedge clk);
        exp_q.delete();
        seg(2,  3'b001, 3'b000, 3'b110, 2'd0);
        seg(2,  3'b000, 3'b001, 3'b110, 2'd0);
        seg(1,  3'b000, 3'b000, 3'b111, 2'd0);
        seg(25, 3'b010, 3'b000, 3'b101, 2'd1);
        seg(2,  3'b000, 3'b010, 3'b101, 2'd1);
        seg(1,  3'b000, 3'b000, 3'b111, 2'd1);
        seg(4,  3'b001, 3'b000, 3'b110, 2'd0);
        for (int c = 0; c < exp_q.size(); c++) begin
            @(posedge clk); #1;
            e = exp_q[c];
            checks++;
            if ({green, yellow, red, phase} !== e) begin
                errors++;
                $display("FAIL hold cyc %0d: got g=%b y=%b r=%b ph=%0d, expected g=%b y=%b r=%b ph=%0d",
                         c, green, yellow, red, phase, e[10:8], e[7:5], e[4:2], e[1:0]);
            end
            req = (c < 29) ? 3'b010 : 3'b000;
        end
    endtask

    task automatic test_reset_mid();
        logic [10:0] e;
        do_reset();
        repeat (8) @(posedge clk);
        exp_q.delete();
        seg(2, 3'b001, 3'b000, 3'b110, 2'd0);
        seg(2, 3'b000, 3'b001, 3'b110, 2'd0);
        for (int c = 0; c < exp_q.size(); c++) begin
            @(posedge clk); #1;
            e = exp_q[c];
            checks++;
            if ({green, yellow, red, phase} !== e) begin
                errors++;
                $display("FAIL reset_mid_pre cyc %0d: got g=%b y=%b r=%b ph=%0d, expected g=%b y=%b r=%b ph=%0d",
                         c, green, yellow, red, phase, e[10:8], e[7:5], e[4:2], e[1:0]);
            end
            req = (c == 0) ? 3'b100 : 3'b000;
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({green, yellow, red, phase} !== {3'b001, 3'b000, 3'b110, 2'd0}) begin
            errors++;
            $display("FAIL reset_mid_async: got g=%b y=%b r=%b ph=%0d, expected g=001 y=000 r=110 ph=0",
                     green, yellow, red, phase);
        end
        #1 rst = 1'b0;
        // a surviving pending[2] would pull the main road out of green after 4 cycles
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({green, yellow, red, phase} !== {3'b001, 3'b000, 3'b110, 2'd0}) begin
                errors++;
                $display("FAIL reset_mid_post cyc %0d: got g=%b y=%b r=%b ph=%0d, expected g=001 y=000 r=110 ph=0",
                         c, green, yellow, red, phase);
            end
        end
    endtask

`ifdef TL_FLASH_EN
    task automatic test_flash();
        logic [10:0] e;
        do_reset();
        exp_q.delete();
        seg(1, 3'b001, 3'b000, 3'b110, 2'd0);
        seg(2, 3'b000, 3'b001, 3'b110, 2'd0);
        seg(1, 3'b000, 3'b000, 3'b111, 2'd0);
        seg(8, 3'b000, 3'b111, 3'b000, 2'd0);
        seg(8, 3'b000, 3'b000, 3'b000, 2'd0);
        seg(2, 3'b000, 3'b111, 3'b000, 2'd0);
        seg(1, 3'b000, 3'b000, 3'b111, 2'd0);
        seg(3, 3'b001, 3'b000, 3'b110, 2'd0);
        for (int c = 0; c < exp_q.size(); c++) begin
            @(posedge clk); #1;
            e = exp_q[c];
            checks++;
            if ({green, yellow, red, phase} !== e) begin
                errors++;
                $display("FAIL flash cyc %0d: got g=%b y=%b r=%b ph=%0d, expected g=%b y=%b r=%b ph=%0d",
                         c, green, yellow, red, phase, e[10:8], e[7:5], e[4:2], e[1:0]);
            end
            flash = (c < 21);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_side();
        test_round_robin();
        test_green_max();
        test_hold();
        test_reset_mid();
`ifdef TL_FLASH_EN
        test_flash();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
